// File: rtl/rand_pos_gen.sv
`default_nettype none
// ============================================================================
// Module   : rand_pos_gen
// Purpose  : Turns a free-running 12-bit random word into an on-screen spawn
//            position for an OBJ_W x OBJ_H object. Each coordinate is drawn by
//            rejection sampling. After MAX_TRIES rejections the next sample is
//            taken unconditionally, and an out-of-range value is folded back
//            into range.
// Ports    : clock       - single clock, rising edge
//            reset       - asynchronous, active-low
//            rand_i      - random word, new value every cycle
//            req_i       - request a spawn position (only seen in IDLE)
//            ack_i       - consumer took the result (only seen in HOLD)
//            busy_o      - high whenever not IDLE
//            valid_o     - pos_x_o/pos_y_o/fallback_o hold a result
//            pos_x_o     - spawn x, 0..X_MAX-OBJ_W
//            pos_y_o     - spawn y, 0..Y_MAX-OBJ_H
//            fallback_o  - at least one coordinate came from the fold path
// Config   : RAND_POS_GRID_EN - when defined, accepted coordinates snap to
//            an 8-pixel grid (bits [2:0] cleared)
// Revision : 1.0 - initial release
// ============================================================================
module rand_pos_gen #(
  parameter int X_MAX     = 640,
  parameter int Y_MAX     = 480,
  parameter int OBJ_W     = 16,
  parameter int OBJ_H     = 16,
  parameter int MAX_TRIES = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] rand_i,
  input  logic        req_i,
  input  logic        ack_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [9:0]  pos_x_o,
  output logic [8:0]  pos_y_o,
  output logic        fallback_o
);

  // The fold subtracts LIMIT+1. Because 2*(LIMIT+1) covers the whole sample
  // space, a folded value always lands back inside 0..LIMIT.
  localparam logic [9:0] X_LIMIT  = 10'(X_MAX - OBJ_W);
  localparam logic [9:0] X_FOLD   = 10'(X_MAX - OBJ_W + 1);
  localparam logic [8:0] Y_LIMIT  = 9'(Y_MAX - OBJ_H);
  localparam logic [8:0] Y_FOLD   = 9'(Y_MAX - OBJ_H + 1);
  localparam logic [3:0] TRY_LAST = 4'(MAX_TRIES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SAMPLE_X = 2'd1,
    SAMPLE_Y = 2'd2,
    HOLD     = 2'd3
  } stateT;

  stateT       rState, wStateNext;
  logic [3:0]  rTryCount;
  logic [9:0]  rPosX;
  logic [8:0]  rPosY;
  logic        rFallback;

  logic        wLoadX, wLoadY, wTryClear, wTryInc, wFbClear;
  logic        wTryAtMax;
  logic [9:0]  wSampleX, wXRaw, wXCoord;
  logic [8:0]  wSampleY, wYRaw, wYCoord;
  logic        wXInRange, wYInRange, wXFold, wYFold;

  // rand_i[11:10] never feed either coordinate.
  logic        unusedRandHi;
  assign unusedRandHi = ^rand_i[11:10];

  assign wTryAtMax = (rTryCount == TRY_LAST);

  assign wSampleX  = rand_i[9:0];
  assign wXInRange = (wSampleX <= X_LIMIT);
  assign wXRaw     = wXInRange ? wSampleX : (wSampleX - X_FOLD);
  assign wXFold    = wTryAtMax && !wXInRange;

  assign wSampleY  = rand_i[8:0];
  assign wYInRange = (wSampleY <= Y_LIMIT);
  assign wYRaw     = wYInRange ? wSampleY : (wSampleY - Y_FOLD);
  assign wYFold    = wTryAtMax && !wYInRange;

`ifdef RAND_POS_GRID_EN
  // Snap after folding so a folded coordinate lands on the grid as well.
  assign wXCoord = {wXRaw[9:3], 3'b000};
  assign wYCoord = {wYRaw[8:3], 3'b000};
  logic unusedGridBits;
  assign unusedGridBits = ^{wXRaw[2:0], wYRaw[2:0]};
`else
  assign wXCoord = wXRaw;
  assign wYCoord = wYRaw;
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rState <= IDLE;
    end else begin
      rState <= wStateNext;
    end
  end

  // Next state and datapath strobes
  always_comb begin
    wStateNext = rState;
    wLoadX     = 1'b0;
    wLoadY     = 1'b0;
    wTryClear  = 1'b0;
    wTryInc    = 1'b0;
    wFbClear   = 1'b0;
    case (rState)
      IDLE: begin
        if (req_i) begin
          wStateNext = SAMPLE_X;
          wTryClear  = 1'b1;
          wFbClear   = 1'b1;
        end
      end
      SAMPLE_X: begin
        if (wXInRange || wTryAtMax) begin
          wLoadX     = 1'b1;
          wTryClear  = 1'b1;
          wStateNext = SAMPLE_Y;
        end else begin
          wTryInc = 1'b1;
        end
      end
      SAMPLE_Y: begin
        if (wYInRange || wTryAtMax) begin
          wLoadY     = 1'b1;
          wStateNext = HOLD;
        end else begin
          wTryInc = 1'b1;
        end
      end
      HOLD: begin
        // A simultaneous req_i is dropped; a new request must come in IDLE.
        if (ack_i) begin
          wStateNext = IDLE;
        end
      end
      default: wStateNext = IDLE;
    endcase
  end

  // Datapath: try counter, coordinates, fallback flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rTryCount <= 4'd0;
      rPosX     <= 10'd0;
      rPosY     <= 9'd0;
      rFallback <= 1'b0;
    end else begin
      if (wTryClear) begin
        rTryCount <= 4'd0;
      end else if (wTryInc) begin
        rTryCount <= rTryCount + 4'd1;
      end

      if (wLoadX) begin
        rPosX <= wXCoord;
      end
      if (wLoadY) begin
        rPosY <= wYCoord;
      end

      if (wFbClear) begin
        rFallback <= 1'b0;
      end else if ((wLoadX && wXFold) || (wLoadY && wYFold)) begin
        rFallback <= 1'b1;
      end
    end
  end

  assign busy_o     = (rState != IDLE);
  assign valid_o    = (rState == HOLD);
  assign pos_x_o    = rPosX;
  assign pos_y_o    = rPosY;
  assign fallback_o = rFallback;

endmodule
`default_nettype wire

// File: doc/rand_pos_gen.md
RAND_POS_GEN -- requirements
Module: rand_pos_gen

Interface
REQ-001 Parameter X_MAX, 640, visible screen width in pixels.
REQ-002 Parameter Y_MAX, 480, visible screen height in pixels.
REQ-003 Parameter OBJ_W, 16, spawned object width in pixels.
REQ-004 Parameter OBJ_H, 16, spawned object height in pixels.
REQ-005 Parameter MAX_TRIES, 15, rejected samples per coordinate before fold fallback (4-bit counter).
REQ-006 Port clock  input  1  single clock; all state on its rising edge.
REQ-007 Port reset  input  1  asynchronous, active-low reset.
REQ-008 Port rand_i  input  12  free-running random word from the upstream RNG; a new value every cycle.
REQ-009 Port req_i  input  1  request one spawn position.
REQ-010 Port ack_i  input  1  consumer has taken the presented position.
REQ-011 Port busy_o  output  1  high in any state other than IDLE.
REQ-012 Port valid_o  output  1  pos_x_o/pos_y_o/fallback_o hold a valid result.
REQ-013 Port pos_x_o  output  10  spawn x, range 0..X_MAX-OBJ_W.
REQ-014 Port pos_y_o  output  9  spawn y, range 0..Y_MAX-OBJ_H.
REQ-015 Port fallback_o  output  1  at least one coordinate of this result came from the fold path.

Function
REQ-016 The block SHALL implement states IDLE, SAMPLE_X, SAMPLE_Y, HOLD.
REQ-017 IDLE: req_i=1 SHALL move to SAMPLE_X next cycle; req_i is ignored in all other states.
REQ-018 SAMPLE_X: each cycle rand_i[9:0] SHALL be accepted into the x register if <= X_MAX-OBJ_W and the state SHALL move to SAMPLE_Y; otherwise the try counter increments.
REQ-019 SAMPLE_Y: each cycle rand_i[8:0] SHALL be accepted into the y register if <= Y_MAX-OBJ_H and the state SHALL move to HOLD; otherwise the try counter increments.
REQ-020 The try counter SHALL clear on entry to SAMPLE_X and to SAMPLE_Y.
REQ-021 When the try counter equals MAX_TRIES, the current sample SHALL be accepted unconditionally: in range as-is, else as sample-(LIMIT+1) where LIMIT is X_MAX-OBJ_W or Y_MAX-OBJ_H; a folded acceptance sets the fallback flag.
REQ-022 Parameters SHALL satisfy 1024 <= 2*(X_MAX-OBJ_W+1) and 512 <= 2*(Y_MAX-OBJ_H+1) so the fold is always in range; defaults comply.
REQ-023 HOLD: valid_o SHALL be 1 and pos_x_o, pos_y_o, fallback_o SHALL be stable until ack_i=1, then the state SHALL return to IDLE with valid_o=0 next cycle.
REQ-024 Minimum latency SHALL be 3 cycles from req_i sampled in IDLE to valid_o=1; maximum SHALL be 2*(MAX_TRIES+1)+1 cycles.
REQ-025 req_i and ack_i both high in HOLD SHALL complete the ack only; a new request needs req_i high in IDLE.
REQ-026 ack_i outside HOLD SHALL be ignored.
REQ-027 fallback_o SHALL clear on entry to SAMPLE_X.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, try counter 0, valid_o=0, busy_o=0, pos_x_o=0, pos_y_o=0, fallback_o=0.
REQ-029 Reset mid-operation SHALL abort the request with no valid_o pulse; operation resumes from IDLE after reset release.

Configuration
REQ-030 With RAND_POS_GRID_EN defined, every accepted coordinate (direct or folded) SHALL have bits [2:0] cleared before registering (8-pixel grid).
REQ-031 Without RAND_POS_GRID_EN, accepted coordinates SHALL be registered at full pixel resolution.

Verification
REQ-032 req_i pulse, rand_i=12'h100 then 12'h0C8 -> valid_o=1 on cycle 3, pos_x_o=256, pos_y_o=200, fallback_o=0.
REQ-033 req_i, rand_i=12'h3FF for 15 cycles then 12'h3FF -> 16th sample folded, pos_x_o=1023-625=398, fallback_o=1.
REQ-034 In HOLD, hold ack_i=0 for 20 cycles while rand_i toggles -> outputs unchanged; ack_i=1 -> valid_o=0, busy_o=0 next cycle.
REQ-035 reset=0 asserted asynchronously in SAMPLE_Y -> all outputs 0 immediately; no valid_o after release until a new req_i.
REQ-036 RAND_POS_GRID_EN defined, rand_i=12'h10F then 12'h0CF -> pos_x_o=264, pos_y_o=200.
